avalon_st_rl_source: RTL and testbench
======================================

Name: avalon_st_rl_source

Overview:
- Avalon-ST transmit-side timing adapter. Accepts beats from a readyLatency=0 upstream (valid/ready) and drives a downstream sink that has readyLatency=READY_LATENCY.
- Downstream rule: out_valid may be high in cycle t only if out_ready was high in cycle t-READY_LATENCY.
- Sits in front of NIOS sopc_system ST sinks that declare readyLatency>0. It is the source-side counterpart of the sink-side timing-adapter FIFO.

Parameters:
DATA_WIDTH, 42, payload width of in_data/out_data
READY_LATENCY, 2, downstream ready latency in cycles; legal range 1..4
BUF_DEPTH, 2, internal buffer entries; fixed at 2, not user-tunable
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream beat valid (RL0)
in_ready  output  1  upstream ready (RL0)
in_data  input  DATA_WIDTH  upstream payload
in_sop  input  1  upstream start-of-packet
in_eop  input  1  upstream end-of-packet
out_ready  input  1  downstream ready (RL=READY_LATENCY)
out_valid  output  1  downstream beat valid, registered
out_data  output  DATA_WIDTH  downstream payload, registered
out_sop  output  1  downstream start-of-packet, registered
out_eop  output  1  downstream end-of-packet, registered
beat_count  output  CNT_WIDTH  beats launched downstream (optional feature)
pkt_count  output  CNT_WIDTH  eop beats launched (optional feature)
proto_err  output  1  sticky upstream framing error (optional feature)

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high, port name reset.
- Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, buffer count=0, ready history=all 0, framing FSM=IDLE, counters=0, proto_err=0.
  - in_ready is forced 0 while reset=1.
- Buffer: 2-entry circular store of {sop,eop,data} with a 2-bit count and 1-bit wr/rd pointers that wrap modulo 2.
  - in_ready = (count != 2) && !reset.
  - Push when in_valid && in_ready.
- Ready history: shift register rh[1..READY_LATENCY], with rh[1] <= out_ready and rh[k] <= rh[k-1].
  - credit = out_ready when READY_LATENCY==1, else rh[READY_LATENCY-1]. This is out_ready as seen READY_LATENCY-1 cycles before the current cycle, so a launch registered this edge appears exactly READY_LATENCY cycles after that ready.
- Launch: launch = credit && (count != 0).
  - On the edge: out_valid <= launch. If launch, out_data/out_sop/out_eop <= head entry and the entry is popped.
  - If no launch, out_valid <= 0 and the data/sop/eop outputs hold their previous values.
- Simultaneous push and pop: count unchanged, both pointers advance.
- A push into an empty buffer cannot launch in the same cycle. Minimum latency from in accept (edge E) to out_valid is 2 edges: E+1 launch decision, visible after E+1.
- Throughput: with out_ready held 1 and in_valid held 1, one beat per cycle after fill. Count settles at 1; in_ready stays 1.
- No beat is ever dropped or duplicated. out_ready low never cancels an already-launched beat, because the sink guarantees acceptance under readyLatency semantics.
- Framing FSM, advanced on upstream accept:
  - IDLE: sop&eop → IDLE; sop&!eop → IN_PKT; !sop → error, stay IDLE.
  - IN_PKT: eop&!sop → IDLE; sop → error, state follows the new beat's eop; otherwise stay IN_PKT.
  - The FSM only flags errors. Beats are always forwarded unchanged.
- Reset mid-packet: buffered beats are discarded, FSM returns to IDLE, out_valid is 0 on the next cycle.

Optional Feature:
- Macro AVST_RL_SRC_STATS_EN.
- Defined:
  - beat_count increments on each launch.
  - pkt_count increments on each launch with eop=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - proto_err sets on any framing error and clears only on reset.
- Undefined: beat_count, pkt_count and proto_err are tied to 0. The framing FSM and counter logic are not built. Data path is identical.

Test Plan:
- Reset release, out_ready=1 constant, 8 single-beat packets (sop=eop=1) in_data 0..7 back-to-back → out_valid first high 2 cycles after first accept; data 0..7 in order on consecutive cycles; in_ready never low; pkt_count=8.
- RL=2, out_ready pulse high for exactly 1 cycle (cycle 10) with 2 beats buffered → exactly one out_valid, at cycle 12; the second beat is held; count=1 afterwards.
- out_ready=0 throughout, 3 beats offered → 2 accepted, in_ready low from the 3rd offer onward, out_valid never high; raise out_ready → 3 beats emerge in order, each exactly READY_LATENCY cycles after its qualifying ready.
- Random in_valid/out_ready (seed 23, 320 cycles) for each of RL=1..4 → scoreboard matches all data, and no out_valid occurs without out_ready high RL cycles earlier.
- Framing: sop,data,sop (no eop) then a beat with sop=0 in IDLE → proto_err=1 after the first violation, all beats still forwarded; with the macro undefined proto_err stays 0.
- Assert reset for 1 cycle with 2 beats buffered mid-packet → out_valid=0 next cycle, buffered beats never appear, a new packet afterwards passes with no error.

Source files
------------

// File: rtl/avalon_st_rl_source_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : avalon_st_rl_source_if                                   |
// | Description : Handshake bundle for avalon_st_rl_source. The upstream   |
// |               side is readyLatency=0, the downstream side is           |
// |               readyLatency=READY_LATENCY.                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface avalon_st_rl_source_if #(
    parameter int DATA_WIDTH = 42
);
    // Upstream, readyLatency = 0
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sop;
    logic                  in_eop;

    // Downstream, readyLatency = READY_LATENCY
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sop;
    logic                  out_eop;

    // Adapter view: it is the ST source towards the downstream sink
    modport master (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );

    // Environment view: upstream source plus downstream sink
    modport slave (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );
endinterface
`default_nettype wire

// File: rtl/avalon_st_rl_source.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : avalon_st_rl_source                                      |
// | Description : Avalon-ST transmit-side timing adapter. Buffers beats    |
// |               from a readyLatency=0 source in a 2-entry store and      |
// |               launches them to a sink with readyLatency=READY_LATENCY, |
// |               only when ready was seen READY_LATENCY cycles earlier.   |
// |               Optional statistics / framing checker are built when the |
// |               macro AVST_RL_SRC_STATS_EN is defined; otherwise         |
// |               beat_count, pkt_count and proto_err are tied to 0.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module avalon_st_rl_source #(
    parameter int DATA_WIDTH    = 42,
    parameter int READY_LATENCY = 2,   // legal range 1..4
    parameter int BUF_DEPTH     = 2,   // fixed; pointers below are 1 bit
    parameter int CNT_WIDTH     = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    avalon_st_rl_source_if.master     st,
    output logic [CNT_WIDTH-1:0]      beat_count,
    output logic [CNT_WIDTH-1:0]      pkt_count,
    output logic                      proto_err
);

    localparam int         c_ENTRY_W = DATA_WIDTH + 2;
    localparam logic [1:0] c_FULL    = 2'(BUF_DEPTH);

    // Buffer storage: each entry is {sop, eop, data}
    logic [c_ENTRY_W-1:0] r_mem [BUF_DEPTH];
    logic [1:0]           r_count;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [c_ENTRY_W-1:0] w_head;

    logic                 w_in_ready;
    logic                 w_push;
    logic                 w_credit;
    logic                 w_launch;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_sop;
    logic                  r_out_eop;

    assign w_in_ready = (r_count != c_FULL) && !reset;
    assign w_push     = st.in_valid && w_in_ready;
    assign w_head     = r_mem[r_rd_ptr];
    // A launch needs ready seen READY_LATENCY-1 cycles ago; registering it
    // makes out_valid appear exactly READY_LATENCY cycles after that ready.
    assign w_launch   = w_credit && (r_count != 2'd0);

    assign st.in_ready  = w_in_ready;
    assign st.out_valid = r_out_valid;
    assign st.out_data  = r_out_data;
    assign st.out_sop   = r_out_sop;
    assign st.out_eop   = r_out_eop;

    // Ready history. The oldest stage rh[READY_LATENCY] is never consulted,
    // so only stages 1..READY_LATENCY-1 are built.
    generate
        if (READY_LATENCY == 1) begin : g_rl_direct
            assign w_credit = st.out_ready;
        end else if (READY_LATENCY == 2) begin : g_rl_two
            logic r_rh;
            // Remember last cycle's downstream ready
            always_ff @(posedge clk) begin
                if (reset) r_rh <= 1'b0;
                else       r_rh <= st.out_ready;
            end
            assign w_credit = r_rh;
        end else begin : g_rl_deep
            logic [READY_LATENCY-2:0] r_rh;
            // Shift downstream ready through the history, newest in bit 0
            always_ff @(posedge clk) begin
                if (reset) r_rh <= '0;
                else       r_rh <= {r_rh[READY_LATENCY-3:0], st.out_ready};
            end
            assign w_credit = r_rh[READY_LATENCY-2];
        end
    endgenerate

    // Write an accepted beat at the write pointer (storage needs no reset)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {st.in_sop, st.in_eop, st.in_data};
    end

    // Occupancy and pointers; a push and a pop in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push)   r_wr_ptr <= ~r_wr_ptr;
            if (w_launch) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_push) - 2'(w_launch);
        end
    end

    // Registered downstream beat; payload holds when nothing is launched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            r_out_valid <= w_launch;
            if (w_launch) {r_out_sop, r_out_eop, r_out_data} <= w_head;
        end
    end

`ifdef AVST_RL_SRC_STATS_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 w_frame_err;
    logic [CNT_WIDTH-1:0] r_beat_count;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic                 r_proto_err;

    // Framing state advances only on an upstream accept
    always_ff @(posedge clk) begin
        if (reset)       r_state <= ST_IDLE;
        else if (w_push) r_state <= w_state_nxt;
    end

    // Framing rules; errors are only flagged, beats pass through unchanged
    always_comb begin
        w_state_nxt = r_state;
        w_frame_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (st.in_sop) w_state_nxt = st.in_eop ? ST_IDLE : ST_IN_PKT;
                else           w_frame_err = 1'b1;
            end
            ST_IN_PKT: begin
                if (st.in_sop) begin
                    w_frame_err = 1'b1;
                    w_state_nxt = st.in_eop ? ST_IDLE : ST_IN_PKT;
                end else if (st.in_eop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Launch statistics (wrapping) and sticky framing error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count <= '0;
            r_pkt_count  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_launch) r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            if (w_launch && w_head[DATA_WIDTH]) r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            if (w_push && w_frame_err) r_proto_err <= 1'b1;
        end
    end

    assign beat_count = r_beat_count;
    assign pkt_count  = r_pkt_count;
    assign proto_err  = r_proto_err;
`else
    assign beat_count = '0;
    assign pkt_count  = '0;
    assign proto_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_rl_source.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_avalon_st_rl_source                                   |
// | Description : Self-checking bench. Four adapters (READY_LATENCY 1..4)  |
// |               share one stimulus; each is compared every cycle with a  |
// |               queue-based model, plus literal expectations on RL=2.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_avalon_st_rl_source;
    localparam int DW = 42;
    localparam int CW = 16;
`ifdef AVST_RL_SRC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_sop    = 1'b0;
    logic          in_eop    = 1'b0;
    logic          out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rdy_log [0:4095];

    // Beats seen at the RL=2 instance, with the cycle they were valid
    logic [DW-1:0] mon_d[$];
    int            mon_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int RL = gi + 1;
        avalon_st_rl_source_if #(.DATA_WIDTH(DW)) u_if ();
        logic [CW-1:0] beat_count;
        logic [CW-1:0] pkt_count;
        logic          proto_err;

        assign u_if.in_valid  = in_valid;
        assign u_if.in_data   = in_data;
        assign u_if.in_sop    = in_sop;
        assign u_if.in_eop    = in_eop;
        assign u_if.out_ready = out_ready;

        avalon_st_rl_source #(
            .DATA_WIDTH(DW), .READY_LATENCY(RL), .BUF_DEPTH(2), .CNT_WIDTH(CW)
        ) u_dut (
            .clk(clk), .reset(reset), .st(u_if.master),
            .beat_count(beat_count), .pkt_count(pkt_count), .proto_err(proto_err)
        );

        // Model: a queue of at most 2 beats; a beat leaves when ready was
        // high RL-1 cycles ago and shows up on the outputs one cycle later.
        logic [DW+1:0] q[$];
        bit            hist [0:2];
        bit            m_valid = 1'b0;
        logic [DW-1:0] m_data  = '0;
        bit            m_sop   = 1'b0;
        bit            m_eop   = 1'b0;
        int            m_beats = 0;
        int            m_pkts  = 0;
        bit            m_inpkt = 1'b0;
        bit            m_perr  = 1'b0;

        always @(posedge clk) begin
            bit            credit;
            bit            acc;
            logic [DW+1:0] e;
            if (reset) begin
                q.delete();
                hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
                m_valid = 1'b0; m_data = '0; m_sop = 1'b0; m_eop = 1'b0;
                m_beats = 0; m_pkts = 0; m_inpkt = 1'b0; m_perr = 1'b0;
            end else begin
                credit  = (RL == 1) ? out_ready : hist[(RL >= 2) ? RL - 2 : 0];
                acc     = in_valid && (q.size() < 2);
                m_valid = credit && (q.size() != 0);
                if (m_valid) begin
                    e = q.pop_front();
                    {m_sop, m_eop, m_data} = e;
                    m_beats++;
                    if (m_eop) m_pkts++;
                end
                if (acc) begin
                    q.push_back({in_sop, in_eop, in_data});
                    // sop is legal exactly when not inside a packet
                    if (in_sop == m_inpkt) m_perr = 1'b1;
                    m_inpkt = in_sop ? !in_eop : (m_inpkt && !in_eop);
                end
                hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = out_ready;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("rl%0d.in_ready", RL), 64'(u_if.in_ready), 64'(!reset && (q.size() < 2)));
            chk($sformatf("rl%0d.out_valid", RL), 64'(u_if.out_valid), 64'(m_valid));
            chk($sformatf("rl%0d.out_data", RL), 64'(u_if.out_data), 64'(m_data));
            chk($sformatf("rl%0d.out_sop", RL), 64'(u_if.out_sop), 64'(m_sop));
            chk($sformatf("rl%0d.out_eop", RL), 64'(u_if.out_eop), 64'(m_eop));
            chk($sformatf("rl%0d.beat_count", RL), 64'(beat_count), STATS ? 64'(CW'(m_beats)) : 64'(0));
            chk($sformatf("rl%0d.pkt_count", RL), 64'(pkt_count), STATS ? 64'(CW'(m_pkts)) : 64'(0));
            chk($sformatf("rl%0d.proto_err", RL), 64'(proto_err), STATS ? 64'(m_perr) : 64'(0));
            if (u_if.out_valid && cyc >= RL && cyc < 4096)
                chk($sformatf("rl%0d.ready_rule", RL), 64'(rdy_log[cyc-RL]), 64'(1));
        end
    end

    always @(negedge clk) begin
        if (cyc < 4096) rdy_log[cyc] = out_ready;
        if (g_inst[1].u_if.out_valid) begin
            mon_d.push_back(g_inst[1].u_if.out_data);
            mon_c.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_d.delete();
        mon_c.delete();
    endtask

    // Offer one beat and hold it until the RL=2 instance accepts it
    task automatic send(input logic [DW-1:0] d, input logic s, input logic e, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
        while (!done && waits < 40) begin
            @(negedge clk);
            done = g_inst[1].u_if.in_ready;
            @(posedge clk); #1;
            if (!done) waits++;
        end
        in_valid = 1'b0;
        chk("send.accepted", 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        step(2);
        reset    = 1'b0;
    endtask

    initial begin
        int acc0;
        int w;
        int p_cyc;
        int r_cyc;
        w = $urandom(23);

        // Reset state
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 64'(g_inst[1].u_if.in_ready), 64'(0));
        chk("rst.out_valid", 64'(g_inst[1].u_if.out_valid), 64'(0));
        chk("rst.out_data", 64'(g_inst[1].u_if.out_data), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        step(2);

        // Back-to-back single-beat packets, ready held high
        mon_clear();
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            send(DW'(i), 1'b1, 1'b1, w);
            chk("t1.no_stall", 64'(w), 64'(0));
            if (i == 0) acc0 = cyc - 1;
        end
        step(5);
        chk("t1.beats", 64'(mon_d.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1.data%0d", i), 64'(mon_d[i]), 64'(i));
            chk($sformatf("t1.cycle%0d", i), 64'(mon_c[i]), 64'(acc0 + 2 + i));
        end
        @(negedge clk);
        chk("t1.pkt_count", 64'(g_inst[1].pkt_count), STATS ? 64'(8) : 64'(0));
        @(posedge clk); #1;

        // One-cycle ready pulse with two beats buffered
        do_reset();
        out_ready = 1'b0;
        step(3);
        send(DW'('h0A), 1'b1, 1'b0, w);
        send(DW'('h0B), 1'b0, 1'b1, w);
        step(2);
        mon_clear();
        out_ready = 1'b1;
        p_cyc = cyc;
        step(1);
        out_ready = 1'b0;
        step(6);
        chk("t2.beats", 64'(mon_d.size()), 64'(1));
        chk("t2.cycle", 64'(mon_c[0]), 64'(p_cyc + 2));
        chk("t2.data", 64'(mon_d[0]), 64'('h0A));
        chk("t2.dut_count", 64'(g_inst[1].u_dut.r_count), 64'(1));
        chk("t2.model_count", 64'(g_inst[1].q.size()), 64'(1));

        // Ready low: two accepted, third stalls until ready returns
        do_reset();
        out_ready = 1'b0;
        step(3);
        mon_clear();
        send(DW'('h11), 1'b1, 1'b0, w);
        chk("t3.first_wait", 64'(w), 64'(0));
        send(DW'('h12), 1'b0, 1'b0, w);
        chk("t3.second_wait", 64'(w), 64'(0));
        in_valid = 1'b1; in_data = DW'('h13); in_sop = 1'b0; in_eop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3.in_ready_low", 64'(g_inst[1].u_if.in_ready), 64'(0));
            @(posedge clk); #1;
        end
        chk("t3.no_out_yet", 64'(mon_d.size()), 64'(0));
        out_ready = 1'b1;
        r_cyc = cyc;
        send(DW'('h13), 1'b0, 1'b1, w);
        chk("t3.third_wait", 64'(w), 64'(2));
        step(8);
        chk("t3.beats", 64'(mon_d.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3.data%0d", i), 64'(mon_d[i]), 64'('h11 + i));
            chk($sformatf("t3.cycle%0d", i), 64'(mon_c[i]), 64'(r_cyc + 2 + i));
        end

        // Random traffic, all four latencies checked against the model
        do_reset();
        for (int i = 0; i < 320; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'({$urandom(), $urandom()});
            in_sop    = 1'($urandom_range(0, 1));
            in_eop    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            step(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(10);

        // Framing errors are flagged while every beat is forwarded
        do_reset();
        out_ready = 1'b1;
        step(3);
        mon_clear();
        send(DW'('h21), 1'b1, 1'b0, w);
        send(DW'('h22), 1'b0, 1'b0, w);
        @(negedge clk);
        chk("t5.err_clear", 64'(g_inst[1].proto_err), 64'(0));
        @(posedge clk); #1;
        send(DW'('h23), 1'b1, 1'b0, w);
        @(negedge clk);
        chk("t5.err_set", 64'(g_inst[1].proto_err), 64'(STATS));
        @(posedge clk); #1;
        send(DW'('h24), 1'b0, 1'b1, w);
        send(DW'('h25), 1'b0, 1'b0, w);
        step(5);
        chk("t5.beats", 64'(mon_d.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            chk($sformatf("t5.data%0d", i), 64'(mon_d[i]), 64'('h21 + i));
        chk("t5.err_sticky", 64'(g_inst[1].proto_err), 64'(STATS));

        // Reset mid-packet discards buffered beats
        do_reset();
        out_ready = 1'b0;
        step(3);
        send(DW'('h31), 1'b1, 1'b0, w);
        send(DW'('h32), 1'b0, 1'b0, w);
        mon_clear();
        reset = 1'b1;
        @(negedge clk);
        chk("t6.in_ready_in_reset", 64'(g_inst[1].u_if.in_ready), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6.out_valid", 64'(g_inst[1].u_if.out_valid), 64'(0));
        chk("t6.dut_count", 64'(g_inst[1].u_dut.r_count), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(3);
        send(DW'('h41), 1'b1, 1'b0, w);
        send(DW'('h42), 1'b0, 1'b1, w);
        step(6);
        chk("t6.beats", 64'(mon_d.size()), 64'(2));
        chk("t6.data0", 64'(mon_d[0]), 64'('h41));
        chk("t6.data1", 64'(mon_d[1]), 64'('h42));
        chk("t6.no_err", 64'(g_inst[1].proto_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
